// File: rtl/msrv32_dmem_ahb_master.sv
// Data-memory AHB-Lite master: turns the core's level load/store requests into
// single non-pipelined AHB transfers and reports completion, data and errors.
module msrv32_dmem_ahb_master (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic [31:0] dmaddr_in,
    input  logic [31:0] dmdata_in,
    input  logic [3:0]  dmwr_mask_in,
    input  logic        dmwr_req_in,
    input  logic        dmrd_req_in,
    input  logic [1:0]  rd_size_in,
    input  logic        hready_in,
    input  logic        hresp_in,
    input  logic [31:0] hrdata_in,
    output logic [31:0] haddr_out,
    output logic        hwrite_out,
    output logic [2:0]  hsize_out,
    output logic [1:0]  htrans_out,
    output logic [31:0] hwdata_out,
    output logic        ahb_ready_out,
    output logic        done_out,
    output logic [31:0] rdata_out,
    output logic        bus_err_out
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 3;

    localparam logic [SW-1:0] HSIZE_BYTE = 3'b000;
    localparam logic [SW-1:0] HSIZE_HALF = 3'b001;
    localparam logic [SW-1:0] HSIZE_WORD = 3'b010;
    localparam logic [1:0]    HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]    HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ADDR = 2'b01,
        S_DATA = 2'b10,
        S_ERR  = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] haddr_q, haddr_d;
    logic          hwrite_q, hwrite_d;
    logic [SW-1:0] hsize_q, hsize_d;
    logic [1:0]    htrans_q, htrans_d;
    logic [DW-1:0] hwdata_q, hwdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          done_q, done_d;
    logic          bus_err_q, bus_err_d;
    logic          ready_q, ready_d;
    logic          mask_err_q, mask_err_d;

    logic [SW-1:0] wr_hsize_c;
    logic          wr_mask_err_c;
    logic [SW-1:0] rd_hsize_c;
    logic [SW-1:0] req_hsize_c;
    logic [AW-1:0] req_addr_c;

    // Transfer size of the incoming request; unsupported write masks become a flagged word access
    always_comb begin
        wr_mask_err_c = 1'b0;
        case (dmwr_mask_in)
            4'b1111:                            wr_hsize_c = HSIZE_WORD;
            4'b0011, 4'b1100:                   wr_hsize_c = HSIZE_HALF;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: wr_hsize_c = HSIZE_BYTE;
            default: begin
                wr_hsize_c    = HSIZE_WORD;
                wr_mask_err_c = 1'b1;
            end
        endcase
        rd_hsize_c  = (rd_size_in == 2'b11) ? HSIZE_WORD : {1'b0, rd_size_in};
        req_hsize_c = dmwr_req_in ? wr_hsize_c : rd_hsize_c;
        case (req_hsize_c)
            HSIZE_WORD: req_addr_c = {dmaddr_in[AW-1:2], 2'b00};
            HSIZE_HALF: req_addr_c = {dmaddr_in[AW-1:1], 1'b0};
            default:    req_addr_c = dmaddr_in;
        endcase
    end

    // Next-state and registered-output values
    always_comb begin
        state_d    = state_q;
        haddr_d    = haddr_q;
        hwrite_d   = hwrite_q;
        hsize_d    = hsize_q;
        hwdata_d   = hwdata_q;
        rdata_d    = rdata_q;
        mask_err_d = mask_err_q;
        done_d     = 1'b0;
        bus_err_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // ready_q is low in the done cycle so a still-held request is not re-issued
                if (ready_q && (dmwr_req_in || dmrd_req_in)) begin
                    state_d    = S_ADDR;
                    haddr_d    = req_addr_c;
                    hsize_d    = req_hsize_c;
                    hwrite_d   = dmwr_req_in;
                    mask_err_d = dmwr_req_in && wr_mask_err_c;
                    if (dmwr_req_in) begin
                        hwdata_d = dmdata_in;
                    end
                end
            end
            S_ADDR: begin
                if (hready_in) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (hready_in) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    bus_err_d = mask_err_q || hresp_in;
                    if (!hwrite_q && !hresp_in) begin
                        rdata_d = hrdata_in;
                    end
                end else if (hresp_in) begin
                    state_d = S_ERR;
                end
            end
            S_ERR: begin
                if (hready_in) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    bus_err_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        htrans_d = (state_d == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
        ready_d  = (state_d == S_IDLE) && !done_d;
    end

    // State and output registers
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            state_q    <= S_IDLE;
            haddr_q    <= '0;
            hwrite_q   <= 1'b0;
            hsize_q    <= HSIZE_WORD;
            htrans_q   <= HTRANS_IDLE;
            hwdata_q   <= '0;
            rdata_q    <= '0;
            done_q     <= 1'b0;
            bus_err_q  <= 1'b0;
            ready_q    <= 1'b0;
            mask_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            haddr_q    <= haddr_d;
            hwrite_q   <= hwrite_d;
            hsize_q    <= hsize_d;
            htrans_q   <= htrans_d;
            hwdata_q   <= hwdata_d;
            rdata_q    <= rdata_d;
            done_q     <= done_d;
            bus_err_q  <= bus_err_d;
            ready_q    <= ready_d;
            mask_err_q <= mask_err_d;
        end
    end

    assign haddr_out     = haddr_q;
    assign hwrite_out    = hwrite_q;
    assign hsize_out     = hsize_q;
    assign htrans_out    = htrans_q;
    assign hwdata_out    = hwdata_q;
    assign rdata_out     = rdata_q;
    assign done_out      = done_q;
    assign bus_err_out   = bus_err_q;
    assign ahb_ready_out = ready_q;

endmodule

// File: tb/tb_msrv32_dmem_ahb_master.sv
// Directed plus randomized bench for the data-memory AHB master.
module tb_msrv32_dmem_ahb_master;

    logic        clk;
    logic        rst_n;
    logic [31:0] dmaddr;
    logic [31:0] dmdata;
    logic [3:0]  dmmask;
    logic        wr_req;
    logic        rd_req;
    logic [1:0]  rd_size;
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic        ahb_ready;
    logic        done;
    logic [31:0] rdata;
    logic        bus_err;

    int          passed;
    int          total;
    logic [31:0] model_rdata;

    msrv32_dmem_ahb_master dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst_n),
        .dmaddr_in            (dmaddr),
        .dmdata_in            (dmdata),
        .dmwr_mask_in         (dmmask),
        .dmwr_req_in          (wr_req),
        .dmrd_req_in          (rd_req),
        .rd_size_in           (rd_size),
        .hready_in            (hready),
        .hresp_in             (hresp),
        .hrdata_in            (hrdata),
        .haddr_out            (haddr),
        .hwrite_out           (hwrite),
        .hsize_out            (hsize),
        .htrans_out           (htrans),
        .hwdata_out           (hwdata),
        .ahb_ready_out        (ahb_ready),
        .done_out             (done),
        .rdata_out            (rdata),
        .bus_err_out          (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transfer; the slave inserts wa address waits, wd data waits,
    // or (err) an ERROR response whose second cycle is delayed by ee waits.
    task automatic run_txn(input bit wr, input bit rd, input bit keep_rd, input bit drop,
                           input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                           input logic [1:0] sz, input int wa, input int wd,
                           input bit err, input int ee, input logic [31:0] hr);
        int          esz;
        bit          merr;
        logic [31:0] eaddr;
        merr = 1'b0;
        if (wr) begin
            if (m == 4'hF)                      esz = 2;
            else if (m == 4'h3 || m == 4'hC)    esz = 1;
            else if ($countones(m) == 1)        esz = 0;
            else begin esz = 2; merr = 1'b1; end
        end else begin
            esz = (sz == 2'd3) ? 2 : int'(sz);
        end
        eaddr = a & ~((32'd1 << esz) - 32'd1);

        chk("idle_ready", 32'(ahb_ready), 32'd1);
        chk("idle_htrans", 32'(htrans), 32'd0);
        dmaddr = a; dmdata = d; dmmask = m; rd_size = sz;
        wr_req = wr; rd_req = rd; hready = 1'b0; hresp = 1'b0;
        step();
        if (drop && !keep_rd) begin
            wr_req = 1'b0; rd_req = 1'b0;
            dmaddr = $urandom; dmdata = $urandom; dmmask = 4'($urandom); rd_size = 2'($urandom);
        end
        chk("addr_htrans", 32'(htrans), 32'h2);
        chk("addr_haddr", haddr, eaddr);
        chk("addr_hwrite", 32'(hwrite), 32'(wr));
        chk("addr_hsize", 32'(hsize), 32'(esz));
        chk("addr_done", 32'(done), 32'd0);
        for (int i = 0; i < wa; i++) begin
            step();
            chk("addrwait_htrans", 32'(htrans), 32'h2);
            chk("addrwait_haddr", haddr, eaddr);
            chk("addrwait_done", 32'(done), 32'd0);
        end
        hready = 1'b1;
        step();
        chk("data_htrans", 32'(htrans), 32'd0);
        chk("data_done", 32'(done), 32'd0);
        if (wr) chk("data_hwdata", hwdata, d);
        hready = 1'b0;
        if (!err) begin
            for (int i = 0; i < wd; i++) begin
                step();
                chk("datawait_done", 32'(done), 32'd0);
                if (wr) chk("datawait_hwdata", hwdata, d);
            end
            hready = 1'b1; hrdata = hr;
        end else begin
            hresp = 1'b1; hrdata = hr;
            step();
            chk("err1_done", 32'(done), 32'd0);
            for (int i = 0; i < ee; i++) begin
                step();
                chk("errwait_done", 32'(done), 32'd0);
            end
            hready = 1'b1;
        end
        step();
        if (!wr && !err) model_rdata = hr;
        chk("fin_done", 32'(done), 32'd1);
        chk("fin_bus_err", 32'(bus_err), 32'(err || merr));
        chk("fin_rdata", rdata, model_rdata);
        chk("fin_ready", 32'(ahb_ready), 32'd0);
        wr_req = 1'b0;
        if (!keep_rd) rd_req = 1'b0;
        hready = 1'b1; hresp = 1'b0; hrdata = $urandom;
        step();
        chk("post_done", 32'(done), 32'd0);
        chk("post_bus_err", 32'(bus_err), 32'd0);
        chk("post_htrans", 32'(htrans), 32'd0);
    endtask

    initial begin
        passed = 0; total = 0; model_rdata = 32'd0;
        rst_n = 1'b1; dmaddr = '0; dmdata = '0; dmmask = '0; wr_req = 1'b0; rd_req = 1'b0;
        rd_size = '0; hready = 1'b1; hresp = 1'b0; hrdata = '0;

        // Reset values while reset is held
        #2 rst_n = 1'b0;
        #1;
        chk("rst_htrans", 32'(htrans), 32'd0);
        chk("rst_haddr", haddr, 32'd0);
        chk("rst_hwdata", hwdata, 32'd0);
        chk("rst_hwrite", 32'(hwrite), 32'd0);
        chk("rst_hsize", 32'(hsize), 32'h2);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_ready", 32'(ahb_ready), 32'd0);
        step();
        chk("rst_ready_held", 32'(ahb_ready), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        step();
        chk("rel_ready", 32'(ahb_ready), 32'd1);

        // Word write, no waits
        run_txn(1, 0, 0, 0, 32'h0000_1003, 32'hDEAD_BEEF, 4'hF, 2'd0, 0, 0, 0, 0, 32'd0);
        // Byte read with two wait states
        run_txn(0, 1, 0, 0, 32'h0000_2001, 32'd0, 4'h0, 2'd0, 1, 1, 0, 0, 32'h0000_5A00);
        // Half read, size 3 treated as word
        run_txn(0, 1, 0, 1, 32'h0000_3003, 32'd0, 4'h0, 2'd1, 0, 0, 0, 0, 32'h1234_5678);
        run_txn(0, 1, 0, 0, 32'h0000_3007, 32'd0, 4'h0, 2'd3, 0, 2, 0, 0, 32'hCAFE_F00D);
        // Simultaneous write and read: write first, read after one idle cycle
        run_txn(1, 1, 1, 0, 32'h0000_4002, 32'h0000_AB00, 4'hC, 2'd2, 0, 0, 0, 0, 32'd0);
        run_txn(0, 1, 0, 0, 32'h0000_4002, 32'd0, 4'h0, 2'd2, 0, 0, 0, 0, 32'h8765_4321);
        // Error responses, rdata untouched
        run_txn(0, 1, 0, 0, 32'h0000_5000, 32'd0, 4'h0, 2'd2, 0, 0, 1, 0, 32'hFFFF_FFFF);
        run_txn(1, 0, 0, 0, 32'h0000_5004, 32'h1111_2222, 4'hF, 2'd0, 1, 0, 1, 2, 32'd0);
        // Illegal mask and byte lanes
        run_txn(1, 0, 0, 0, 32'h0000_6001, 32'h00FF_00FF, 4'h5, 2'd0, 0, 0, 0, 0, 32'd0);
        run_txn(1, 0, 0, 1, 32'h0000_6003, 32'hEE00_0000, 4'h8, 2'd0, 0, 1, 0, 0, 32'd0);

        // Reset during a stalled data phase abandons the transfer
        dmaddr = 32'h0000_7000; rd_size = 2'd2; rd_req = 1'b1; hready = 1'b1;
        step();
        chk("rstx_addr_htrans", 32'(htrans), 32'h2);
        step();
        hready = 1'b0;
        chk("rstx_data_htrans", 32'(htrans), 32'd0);
        step();
        rst_n = 1'b0;
        #1;
        chk("rstx_htrans", 32'(htrans), 32'd0);
        chk("rstx_ready", 32'(ahb_ready), 32'd0);
        chk("rstx_done", 32'(done), 32'd0);
        chk("rstx_rdata", rdata, 32'd0);
        model_rdata = 32'd0;
        hready = 1'b1; rd_req = 1'b0;
        step();
        chk("rstx_done_held", 32'(done), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        step();
        chk("rstx_rel_ready", 32'(ahb_ready), 32'd1);
        chk("rstx_rel_done", 32'(done), 32'd0);
        run_txn(0, 1, 0, 0, 32'h0000_7002, 32'd0, 4'h0, 2'd1, 0, 0, 0, 0, 32'h0BAD_CAFE);

        // Randomized transfers against the model
        for (int n = 0; n < 40; n++) begin
            bit          w;
            bit          r;
            logic [31:0] a;
            w = 1'($urandom);
            r = !w || ($urandom_range(0, 3) == 0);
            a = $urandom;
            run_txn(w, r, 0, 1'($urandom), a, $urandom, 4'($urandom), 2'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 4) == 0),
                    $urandom_range(0, 2), $urandom);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/msrv32_dmem_ahb_master.md
MSRV32_DMEM_AHB_MASTER -- requirements
Module: msrv32_dmem_ahb_master

Interface
REQ-001 SHALL have one clock, ms_riscv32_mp_clk_in (input, 1), rising-edge; all state changes on this edge.
REQ-002 SHALL have one reset, ms_riscv32_mp_rst_in (input, 1); reset is asynchronous and active-low.
REQ-003 SHALL have dmaddr_in (input, 32): byte address from the store unit or load path.
REQ-004 SHALL have dmdata_in (input, 32): write data, already lane-aligned by the store unit.
REQ-005 SHALL have dmwr_mask_in (input, 4): byte-lane enables for a write.
REQ-006 SHALL have dmwr_req_in (input, 1) and dmrd_req_in (input, 1): level requests, held high until done_out.
REQ-007 SHALL have rd_size_in (input, 2): load size, 0 = byte, 1 = half, 2 = word.
REQ-008 SHALL have hready_in (input, 1), hresp_in (input, 1, 1 = ERROR) and hrdata_in (input, 32).
REQ-009 SHALL have haddr_out (output, 32), hwrite_out (output, 1), hsize_out (output, 3), htrans_out (output, 2) and hwdata_out (output, 32).
REQ-010 SHALL have ahb_ready_out (output, 1): high when idle and able to accept a request; feeds the store unit ahb_ready_in.
REQ-011 SHALL have done_out (output, 1), rdata_out (output, 32) and bus_err_out (output, 1).

Function
REQ-012 SHALL implement a four-state FSM: IDLE, ADDR, DATA, ERR.
REQ-013 IDLE: ahb_ready_out = 1 and htrans_out = 2'b00. If dmwr_req_in = 1, the block SHALL register addr/data/mask/hwrite = 1 and go to ADDR. Otherwise, if dmrd_req_in = 1, it SHALL register addr/size/hwrite = 0 and go to ADDR.
REQ-014 If dmwr_req_in and dmrd_req_in are both high in IDLE, the write SHALL be served first. The read stays pending and SHALL be accepted in the first IDLE cycle after done_out.
REQ-015 ADDR: htrans_out = 2'b10 (NONSEQ), and haddr, hwrite and hsize are stable. On hready_in = 1 the FSM SHALL go to DATA; otherwise it SHALL hold with all address-phase outputs unchanged.
REQ-016 DATA: htrans_out = 2'b00, and hwdata_out = registered write data, held stable until the phase completes.
REQ-017 DATA, hready_in = 1 and hresp_in = 0: done_out SHALL pulse high for exactly 1 cycle. For reads, rdata_out <= hrdata_in on the same edge. The FSM SHALL then return to IDLE.
REQ-018 DATA, hready_in = 0 and hresp_in = 1: the FSM SHALL go to ERR (first error cycle).
REQ-019 ERR: on hready_in = 1, the block SHALL pulse done_out and bus_err_out for 1 cycle, leave rdata_out unchanged, and return to IDLE. It SHALL remain in ERR while hready_in = 0.
REQ-020 hsize_out for writes SHALL be decoded from the mask:
- 1111 -> 3'b010
- 0011 or 1100 -> 3'b001
- one-hot -> 3'b000
- any other mask -> 3'b010, with bus_err_out pulsed at done_out
REQ-021 hsize_out for reads SHALL be {1'b0, rd_size_in}. The value 2'b11 SHALL be treated as word.
REQ-022 haddr_out SHALL be the registered dmaddr_in with bits [1:0] forced to 0 for word size and bit [0] forced to 0 for half size.
REQ-023 Minimum latency SHALL be 3 cycles from request sampled in IDLE to done_out (IDLE->ADDR->DATA->IDLE with hready_in = 1 throughout). Each wait-state cycle adds exactly 1 cycle.
REQ-024 Requests SHALL be sampled only in IDLE. Requests deasserted mid-transfer SHALL NOT abort the bus transfer.
REQ-025 Back-to-back transfers: one IDLE cycle is required between done_out and the next ADDR; no pipelined address overlap.

Reset
REQ-026 On ms_riscv32_mp_rst_in = 0, the block SHALL go to IDLE immediately, independent of the clock.
REQ-027 During reset, outputs SHALL be:
- htrans_out = 2'b00
- haddr_out = 0, hwdata_out = 0, hwrite_out = 0, hsize_out = 3'b010
- rdata_out = 0, done_out = 0, bus_err_out = 0
- ahb_ready_out = 0 while reset is asserted, 1 in the first IDLE cycle after release
REQ-028 Reset asserted during ADDR, DATA or ERR SHALL abandon the transfer with no done_out pulse.

Verification
REQ-029 Word write, zero wait states: addr 0x0000_1003, data 0xDEAD_BEEF, mask 1111 -> ADDR cycle with haddr 0x0000_1000, hsize 010, htrans 10, hwrite 1; DATA cycle with hwdata 0xDEAD_BEEF; done_out high on cycle 3.
REQ-030 Byte read with 2 wait states: addr 0x0000_2001, size 0, hrdata 0x0000_5A00 -> haddr 0x0000_2001, hsize 000; done_out on cycle 5; rdata_out = 0x0000_5A00.
REQ-031 Simultaneous wr/rd requests -> write transfer completes first, then exactly one IDLE cycle, then read ADDR; two done_out pulses total.
REQ-032 Error response: hresp 1 with hready 0, then hresp 1 with hready 1 -> done_out = bus_err_out = 1 for 1 cycle; rdata_out unchanged; FSM returns to IDLE.
REQ-033 Reset pulsed low in DATA with hready_in = 0 -> htrans 00 and ahb_ready_out 0 immediately; no done_out; after release the next request completes normally.
REQ-034 Illegal mask 0101 -> hsize 010 on the bus; bus_err_out pulses together with done_out.
